tri_dispatch: RTL and testbench
===============================

Name: tri_dispatch

Overview:
Schedules triangles from NREQ independent geometry requesters into the single rasterizer core. It uses round-robin arbitration among requesters and latches the granted 144-bit triangle word. It serializes that word MSB-first onto the rasterizer's serial data input, then holds off further dispatch until the rasterizer pulses DONE or a watchdog expires. It sits directly upstream of the rasterizer and owns its D input.

Parameters:
NREQ, 2, number of requesters (1..8)
TRI_BITS, 144, triangle word width: {x0,x1,x2,y0,y1,y2,c0,c1,c2}, 16b Q10.6 each, x0 in [143:128]
TO_W, 21, watchdog counter width
TIMEOUT, 2000000, max cycles in WAIT_DONE before abort (< 2^TO_W)

Ports:
CLK  in  1  clock; all logic on rising edge
RST_N  in  1  asynchronous, active-low reset
EN  in  1  dispatch enable; low blocks new grants, in-flight triangle completes
REQ  in  NREQ  per-requester request; held with TRI_IN stable until GNT seen
TRI_IN  in  NREQ*TRI_BITS  requester i word at [i*TRI_BITS +: TRI_BITS]
GNT  out  NREQ  one-hot, one-cycle pulse: word i captured
D_OUT  out  1  serial triangle data to rasterizer D
FRAME_START  out  1  high during the cycle carrying bit 143
R_DONE  in  1  rasterizer DONE pulse
BUSY  out  1  high in SHIFT or WAIT_DONE
ACTIVE_ID  out  3  index of triangle in flight (valid while BUSY)
TIMEOUT_ERR  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (async, RST_N=0): state=IDLE; GNT=0, D_OUT=0, FRAME_START=0, BUSY=0, ACTIVE_ID=0, TIMEOUT_ERR=0; rr pointer=0; shift and watchdog counters=0. Reset mid-shift or mid-wait drops the triangle silently, with no GNT replay.
- States: IDLE, SHIFT, WAIT_DONE.
- IDLE:
  - When EN=1 and |REQ at edge k, pick the first i with REQ[i]=1, searching from the pointer upward with wrap.
  - Latch TRI_IN slice i into shift reg and set ACTIVE_ID=i.
  - Next state SHIFT; pointer<=(i+1) mod NREQ.
  - GNT[i]=1 during cycle k+1 only.
- SHIFT:
  - Cycles k+1..k+144: D_OUT=shreg[143], then shift left one each edge.
  - FRAME_START=1 in cycle k+1 only.
  - Bit counter 0..143; at count 143, next state WAIT_DONE and D_OUT returns to 0.
  - R_DONE during SHIFT is ignored.
- WAIT_DONE:
  - Watchdog counts from 0 each cycle.
  - R_DONE=1 -> IDLE next edge. A new grant is possible on the first IDLE cycle, so minimum triangle-to-triangle spacing is 146 cycles + rasterization time.
  - Watchdog reaching TIMEOUT-1 without R_DONE -> set TIMEOUT_ERR, then IDLE.
  - R_DONE and timeout on the same edge: treat as DONE; TIMEOUT_ERR not set.
- D_OUT=0 whenever not in SHIFT.
- EN deasserted during SHIFT or WAIT_DONE has no effect until return to IDLE.
- REQ dropping before grant: no grant is issued and no state is kept.
- Single requester with REQ held continuously: granted once per IDLE visit. The requester must drop REQ within 145 cycles of GNT or it is re-granted with the same data.
- NREQ=1: pointer stays 0.

Decomposition:
- Package raster_pkg:
  - TRI_BITS=144, COORD_W=16, FRAC=6.
  - Field offset constants (X0_MSB=143 ... C2_LSB=0).
  - State enum {IDLE, SHIFT, WAIT_DONE}.
- Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant, grant index, any. Combinational. The pointer register lives in tri_dispatch.

Test Plan:
- Reset, then REQ=01 with TRI_IN[0]=0xA5A5_0000…_0001 -> GNT=01 one cycle later; D_OUT shows 1,0,1,0,0,1,0,1 on its first 8 bits and last bit 1; FRAME_START on the first bit only; BUSY=1 for 145+ cycles.
- REQ=11 held, R_DONE pulsed 10 cycles after each shift -> grant order 0,1,0,1; each GNT pulse exactly 1 cycle; no overlap of SHIFT periods.
- EN=0 with REQ=10 -> no GNT, D_OUT=0. EN=1 -> GNT=10 next cycle, ACTIVE_ID=1.
- R_DONE pulsed mid-SHIFT at bit 50 -> ignored; enters WAIT_DONE and waits for a later R_DONE.
- TIMEOUT=100, no R_DONE -> exactly 100 WAIT_DONE cycles, then TIMEOUT_ERR=1 and return to IDLE. Next REQ is still granted; TIMEOUT_ERR remains 1.
- RST_N low at shift bit 70 -> all outputs 0 immediately (async). After release with REQ=01 still high -> fresh grant, and the full 144 bits are resent from bit 143.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared rasterizer-front-end constants: triangle word layout and dispatcher states.
package raster_pkg;

   localparam int unsigned TRI_BITS = 144;
   localparam int unsigned COORD_W  = 16;
   localparam int unsigned FRAC     = 6;

   // Field layout {x0,x1,x2,y0,y1,y2,c0,c1,c2}, each COORD_W bits in Q10.6
   localparam int unsigned X0_MSB = 143;
   localparam int unsigned X0_LSB = 128;
   localparam int unsigned X1_MSB = 127;
   localparam int unsigned X1_LSB = 112;
   localparam int unsigned X2_MSB = 111;
   localparam int unsigned X2_LSB = 96;
   localparam int unsigned Y0_MSB = 95;
   localparam int unsigned Y0_LSB = 80;
   localparam int unsigned Y1_MSB = 79;
   localparam int unsigned Y1_LSB = 64;
   localparam int unsigned Y2_MSB = 63;
   localparam int unsigned Y2_LSB = 48;
   localparam int unsigned C0_MSB = 47;
   localparam int unsigned C0_LSB = 32;
   localparam int unsigned C1_MSB = 31;
   localparam int unsigned C1_LSB = 16;
   localparam int unsigned C2_MSB = 15;
   localparam int unsigned C2_LSB = 0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT_DONE
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      ptr,
   output logic [NREQ-1:0] grant,
   output logic [2:0]      idx,
   output logic            any
);

   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      any   = |req;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned j;
         j = 32'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = j[2:0];
         end
      end
   end

endmodule

// File: rtl/tri_dispatch.sv
// Round-robin triangle dispatcher: grants one requester, serializes its 144-bit word
// MSB-first to the rasterizer, then waits for DONE or a watchdog abort.
module tri_dispatch #(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned TRI_BITS = 144,
   parameter int unsigned TO_W     = 21,
   parameter int unsigned TIMEOUT  = 2000000
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     EN,
   input  logic [NREQ-1:0]          REQ,
   input  logic [NREQ*TRI_BITS-1:0] TRI_IN,
   output logic [NREQ-1:0]          GNT,
   output logic                     D_OUT,
   output logic                     FRAME_START,
   input  logic                     R_DONE,
   output logic                     BUSY,
   output logic [2:0]               ACTIVE_ID,
   output logic                     TIMEOUT_ERR
);

   import raster_pkg::*;

   localparam int unsigned CNT_W = $clog2(TRI_BITS);

   state_t              state;
   logic [TRI_BITS-1:0] shreg;
   logic [CNT_W-1:0]    bit_cnt;
   logic [TO_W-1:0]     wd_cnt;
   logic [2:0]          rr_ptr;

   logic [NREQ-1:0]     arb_grant;
   logic [2:0]          arb_idx;
   logic                arb_any;
   logic [2:0]          ptr_next;
   logic [TRI_BITS-1:0] sel_word;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (REQ),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (arb_idx == 3'(i)) sel_word = TRI_IN[i*TRI_BITS +: TRI_BITS];
      end
   end

   always_comb begin
      ptr_next = arb_idx + 3'd1;
      if (32'(arb_idx) + 1 >= NREQ) ptr_next = '0;
   end

   // D_OUT is registered one bit ahead so it equals shreg[MSB] during each SHIFT cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         wd_cnt      <= '0;
         rr_ptr      <= '0;
         GNT         <= '0;
         D_OUT       <= 1'b0;
         FRAME_START <= 1'b0;
         BUSY        <= 1'b0;
         ACTIVE_ID   <= '0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         GNT <= '0;
         case (state)
            IDLE: begin
               if (EN && arb_any) begin
                  state       <= SHIFT;
                  shreg       <= sel_word;
                  D_OUT       <= sel_word[TRI_BITS-1];
                  FRAME_START <= 1'b1;
                  GNT         <= arb_grant;
                  ACTIVE_ID   <= arb_idx;
                  BUSY        <= 1'b1;
                  rr_ptr      <= ptr_next;
                  bit_cnt     <= '0;
               end
            end
            SHIFT: begin
               FRAME_START <= 1'b0;
               if (bit_cnt == CNT_W'(TRI_BITS-1)) begin
                  state   <= WAIT_DONE;
                  D_OUT   <= 1'b0;
                  bit_cnt <= '0;
                  wd_cnt  <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shreg   <= shreg << 1;
                  D_OUT   <= shreg[TRI_BITS-2];
               end
            end
            WAIT_DONE: begin
               if (R_DONE) begin
                  state  <= IDLE;
                  BUSY   <= 1'b0;
                  wd_cnt <= '0;
               end else if (wd_cnt == TO_W'(TIMEOUT-1)) begin
                  state       <= IDLE;
                  BUSY        <= 1'b0;
                  TIMEOUT_ERR <= 1'b1;
                  wd_cnt      <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_dispatch.sv
// Directed bench for tri_dispatch: arbitration order, serialization, DONE/timeout, reset.
module tb_tri_dispatch;

   localparam int unsigned NREQ = 2;
   localparam int unsigned TB   = 144;

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              EN;
   logic [NREQ-1:0]   REQ;
   logic [NREQ*TB-1:0] TRI_IN;
   logic [NREQ-1:0]   GNT;
   logic              D_OUT;
   logic              FRAME_START;
   logic              R_DONE;
   logic              BUSY;
   logic [2:0]        ACTIVE_ID;
   logic              TIMEOUT_ERR;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [TB-1:0] W0 = 144'hA5A5_0000_0000_0000_0000_0000_0000_0000_0001;
   localparam logic [TB-1:0] W1 = 144'h0F0F_1234_5678_9ABC_DEF0_1357_2468_ACE0_8001;

   tri_dispatch #(.NREQ(NREQ), .TRI_BITS(TB), .TO_W(21), .TIMEOUT(100)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .REQ(REQ), .TRI_IN(TRI_IN),
      .GNT(GNT), .D_OUT(D_OUT), .FRAME_START(FRAME_START), .R_DONE(R_DONE),
      .BUSY(BUSY), .ACTIVE_ID(ACTIVE_ID), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant edge, then 144 serial bits; leaves the bench in the first WAIT_DONE cycle.
   task automatic capture(input int idx, input logic [TB-1:0] w,
                          input logic [NREQ-1:0] req_after, input int done_at);
      logic [TB-1:0] got;
      int extra_fs, extra_gnt, busy_low;
      got = '0; extra_fs = 0; extra_gnt = 0; busy_low = 0;
      tick();
      check("gnt_onehot", 32'(GNT), 32'(1 << idx));
      check("active_id", 32'(ACTIVE_ID), 32'(idx));
      check("frame_start_first", 32'(FRAME_START), 32'd1);
      for (int b = 0; b < int'(TB); b++) begin
         got[TB-1-b] = D_OUT;
         if (b > 0 && FRAME_START) extra_fs++;
         if (b > 0 && GNT != '0) extra_gnt++;
         if (!BUSY) busy_low++;
         if (b == 0) REQ = req_after;
         R_DONE = (b == done_at);
         tick();
      end
      R_DONE = 1'b0;
      n_checks++;
      assert (got === w) else begin
         n_errors++;
         $error("FAIL serial_word: observed %h expected %h", got, w);
      end
      check("frame_start_once", 32'(extra_fs), 32'd0);
      check("gnt_one_cycle", 32'(extra_gnt), 32'd0);
      check("busy_in_shift", 32'(busy_low), 32'd0);
      check("dout_after_shift", 32'(D_OUT), 32'd0);
      check("busy_wait_done", 32'(BUSY), 32'd1);
   endtask

   task automatic finish_done(input int delay);
      int busy_low;
      busy_low = 0;
      for (int i = 0; i < delay; i++) begin
         if (!BUSY) busy_low++;
         tick();
      end
      check("busy_until_done", 32'(busy_low), 32'd0);
      R_DONE = 1'b1;
      tick();
      R_DONE = 1'b0;
      check("idle_after_done", 32'({BUSY, D_OUT, GNT}), 32'd0);
   endtask

   initial begin
      logic [TB-1:0] got;
      int n;
      RST_N = 1'b0; EN = 1'b1; REQ = '0; R_DONE = 1'b0;
      TRI_IN = {W1, W0};
      tick(); tick();
      check("reset_outputs",
            32'({GNT, D_OUT, FRAME_START, BUSY, ACTIVE_ID, TIMEOUT_ERR}), 32'd0);
      RST_N = 1'b1;

      // Single request from requester 0; explicit look at the first byte and last bit
      REQ = 2'b01;
      tick();
      check("t1_gnt", 32'(GNT), 32'h1);
      got = '0;
      for (int b = 0; b < int'(TB); b++) begin
         got[TB-1-b] = D_OUT;
         if (b == 0) REQ = 2'b00;
         tick();
      end
      check("t1_first_byte", 32'(got[143:136]), 32'hA5);
      check("t1_last_bit", 32'(got[0]), 32'd1);
      check("t1_busy_wait", 32'(BUSY), 32'd1);
      finish_done(10);

      // EN low blocks the grant; enabling grants requester 1 (pointer is now 1)
      EN = 1'b0; REQ = 2'b10;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (GNT != '0 || D_OUT || BUSY) n++;
      end
      check("en_low_no_grant", 32'(n), 32'd0);
      EN = 1'b1;
      capture(1, W1, 2'b00, -1);
      finish_done(10);

      // Both requesting continuously: order must alternate 0,1,0,1
      REQ = 2'b11;
      capture(0, W0, 2'b11, -1);
      finish_done(10);
      capture(1, W1, 2'b11, -1);
      finish_done(10);
      capture(0, W0, 2'b11, -1);
      finish_done(10);
      capture(1, W1, 2'b00, -1);
      finish_done(10);

      // R_DONE during SHIFT is ignored
      REQ = 2'b01;
      capture(0, W0, 2'b00, 50);
      finish_done(5);

      // Watchdog: exactly 100 WAIT_DONE cycles, then sticky error
      REQ = 2'b10;
      capture(1, W1, 2'b00, -1);
      check("err_before_timeout", 32'(TIMEOUT_ERR), 32'd0);
      n = 0;
      while (BUSY && n < 200) begin
         n++;
         tick();
      end
      check("timeout_cycles", 32'(n), 32'd100);
      check("timeout_err_set", 32'(TIMEOUT_ERR), 32'd1);
      REQ = 2'b01;
      capture(0, W0, 2'b00, -1);
      finish_done(3);
      check("timeout_err_sticky", 32'(TIMEOUT_ERR), 32'd1);

      // Async reset mid-shift, then a fresh grant resends the whole word
      REQ = 2'b01;
      tick();
      check("t6_gnt", 32'(GNT), 32'h1);
      repeat (70) tick();
      check("t6_busy_mid", 32'(BUSY), 32'd1);
      RST_N = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({GNT, D_OUT, FRAME_START, BUSY, ACTIVE_ID, TIMEOUT_ERR}), 32'd0);
      tick();
      RST_N = 1'b1;
      capture(0, W0, 2'b00, -1);
      finish_done(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
